// File: rtl/sched_pkg.sv
// sched_pkg: constants and helpers shared by the adder-tree scheduler.
// Holds the FP16 lane width, the default lane count, the FP16 adder tree
// timing (adder latency, tree depth, total latency) and tag_w(), which
// gives the width of a requester index (at least one bit).
package sched_pkg;

  localparam int FP16_DW    = 16;
  localparam int DEF_N      = 128;
  localparam int ADD_LAT    = 11;
  localparam int TREE_DEPTH = 7;
  localparam int TREE_LAT   = ADD_LAT * TREE_DEPTH;

  // Width needed to hold a requester index; a single requester still
  // gets a one-bit tag so every vector has a nonzero width.
  function automatic int tag_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// sched_tag_fifo: synchronous FIFO that records which requester owns each
// reduction currently inside the adder tree.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers and count)
//   push       write push_data at the tail (ignored when full)
//   push_data  W-bit tag
//   pop        drop the head entry (ignored when empty)
//   head       W-bit tag at the head (show-ahead)
//   count      number of stored entries, 0..DEPTH
//   empty/full occupancy flags
module sched_tag_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int W     = 1,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap explicitly so a non-power-of-two depth still works.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage is pure data; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin scheduler sharing one FP16 adder tree among
// NREQ requesters. Each granted vector is launched into the tree one cycle
// after the transfer, and its requester index is queued as a tag; results
// returning from the tree pop the tag and are steered to the owner.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid        per-requester offer
//   req_data         NREQ slices of N lanes x DW bits
//   req_ready        one-hot grant (combinational)
//   tree_valid_in    launch strobe to the tree
//   tree_in_flat     launched vector
//   tree_sum         tree result
//   tree_valid_out   tree result strobe
//   res_valid        one-cycle pulse to the owning requester
//   res_sum          result value, meaningful while res_valid is nonzero
//   busy             reductions in flight or a launch this cycle
//   err_orphan       sticky: a tree result arrived with no tag queued
// Optional build macro SCHED_PERF_CNT_EN adds saturating counters:
//   grant_cnt        NREQ x 32-bit transfers per requester
//   stall_cnt        32-bit cycles with an offer but no grant
module adder_tree_sched
  import sched_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int N            = DEF_N,
  parameter int DW           = FP16_DW,
  parameter int MAX_INFLIGHT = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*N*DW-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tree_valid_in,
  output logic [N*DW-1:0]      tree_in_flat,
  input  logic [DW-1:0]        tree_sum,
  input  logic                 tree_valid_out,
  output logic [NREQ-1:0]      res_valid,
  output logic [DW-1:0]        res_sum,
  output logic                 busy,
  output logic                 err_orphan
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [NREQ*32-1:0]   grant_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int TW = tag_w(NREQ);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   grant_idx;
  logic            grant_found;
  int              scan_idx;

  logic [TW-1:0]   fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;

  logic            vld_p1;
  logic [N*DW-1:0] flat_p1;
  logic [NREQ-1:0] res_vld_p1;
  logic [DW-1:0]   res_sum_p1;
  logic            orphan_q;

`ifdef SCHED_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
`endif

  // Arbiter: scan from the round-robin pointer; a full FIFO blocks even if
  // a pop happens this cycle, since the slot only frees at the next edge.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    scan_idx    = 0;
    if (!rst && !fifo_full) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NREQ;
        if (!grant_found && req_valid[scan_idx]) begin
          grant_found = 1'b1;
          grant_idx   = TW'(scan_idx);
        end
      end
      if (grant_found) req_ready[grant_idx] = 1'b1;
    end
  end

  assign pop = tree_valid_out && !fifo_empty;

  sched_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_found),
    .push_data (grant_idx),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ---- p0 -> p1: launch granted vector into the tree, return results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      vld_p1     <= 1'b0;
      flat_p1    <= '0;
      res_vld_p1 <= '0;
      res_sum_p1 <= '0;
      orphan_q   <= 1'b0;
    end else begin
      vld_p1 <= grant_found;
      if (grant_found) begin
        rr_ptr  <= TW'((int'(grant_idx) + 1) % NREQ);
        flat_p1 <= req_data[int'(grant_idx)*N*DW +: N*DW];
      end
      res_vld_p1 <= pop ? (NREQ'(1) << fifo_head) : '0;
      if (pop) res_sum_p1 <= tree_sum;
      if (tree_valid_out && fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign tree_valid_in = vld_p1;
  assign tree_in_flat  = flat_p1;
  assign res_valid     = res_vld_p1;
  assign res_sum       = res_sum_p1;
  assign err_orphan    = orphan_q;
  assign busy          = (fifo_count != '0) || vld_p1;

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) grant_cnt[i*32 +: 32] <= sat_inc(grant_cnt[i*32 +: 32]);
      end
      if ((|req_valid) && !grant_found) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with NREQ=2 and a 4-deep tag FIFO.
// The bench plays the adder tree itself, returning hand-computed sums.
module tb_adder_tree_sched;
  import sched_pkg::*;

  localparam int NREQ = 2;
  localparam int N    = DEF_N;
  localparam int DW   = FP16_DW;
  localparam int MAXI = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*N*DW-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tree_valid_in;
  logic [N*DW-1:0]      tree_in_flat;
  logic [DW-1:0]        tree_sum;
  logic                 tree_valid_out;
  logic [NREQ-1:0]      res_valid;
  logic [DW-1:0]        res_sum;
  logic                 busy;
  logic                 err_orphan;
`ifdef SCHED_PERF_CNT_EN
  logic [NREQ*32-1:0]   grant_cnt;
  logic [31:0]          stall_cnt;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  adder_tree_sched #(
    .NREQ         (NREQ),
    .N            (N),
    .DW           (DW),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .tree_valid_in  (tree_valid_in),
    .tree_in_flat   (tree_in_flat),
    .tree_sum       (tree_sum),
    .tree_valid_out (tree_valid_out),
    .res_valid      (res_valid),
    .res_sum        (res_sum),
    .busy           (busy),
    .err_orphan     (err_orphan)
`ifdef SCHED_PERF_CNT_EN
    ,
    .grant_cnt      (grant_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of lanes in v that differ from the given lane value.
  function automatic int lane_diff(input logic [N*DW-1:0] v, input logic [DW-1:0] lane);
    int d = 0;
    for (int j = 0; j < N; j++) begin
      if (v[j*DW +: DW] !== lane) d++;
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    tree_sum       = '0;
    tree_valid_out = 1'b0;
    for (int j = 0; j < N; j++) begin
      req_data[j*DW +: DW]     = 16'h3C00;
      req_data[(N+j)*DW +: DW] = 16'h4000;
    end

    // Reset state, and no grants while reset is held.
    tick();
    tick();
    req_valid = 2'b11;
    #1;
    chk("ready_in_rst", 64'(req_ready), 64'h0);
    chk("rst_tvi", 64'(tree_valid_in), 64'h0);
    chk("rst_flat", 64'(lane_diff(tree_in_flat, 16'h0000)), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_res_sum", 64'(res_sum), 64'h0);
    chk("rst_orphan", 64'(err_orphan), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // Round-robin 0,1,0,1 until the 4-deep FIFO fills.
    rst = 1'b0;
    #1;
    chk("ready_g0", 64'(req_ready), 64'h1);
    tick();
    chk("tvi_g0", 64'(tree_valid_in), 64'h1);
    chk("flat_g0", 64'(lane_diff(tree_in_flat, 16'h3C00)), 64'h0);
    chk("ready_g1", 64'(req_ready), 64'h2);
    tick();
    chk("flat_g1", 64'(lane_diff(tree_in_flat, 16'h4000)), 64'h0);
    chk("ready_g2", 64'(req_ready), 64'h1);
    tick();
    chk("ready_g3", 64'(req_ready), 64'h2);
    tick();
    chk("ready_full", 64'(req_ready), 64'h0);
    chk("busy_full", 64'(busy), 64'h1);
    tick();
    chk("tvi_idle", 64'(tree_valid_in), 64'h0);
    chk("flat_hold", 64'(lane_diff(tree_in_flat, 16'h4000)), 64'h0);

    // Tree returns while full: the pop does not unblock this cycle.
    tree_valid_out = 1'b1;
    tree_sum       = 16'h5800;
    #1;
    chk("ready_full_pop", 64'(req_ready), 64'h0);
    tick();
    chk("res0_valid", 64'(res_valid), 64'h1);
    chk("res0_sum", 64'(res_sum), 64'h5800);
    chk("ready_after_pop", 64'(req_ready), 64'h1);
    tree_sum = 16'h5C00;
    tick();
    chk("res1_valid", 64'(res_valid), 64'h2);
    chk("res1_sum", 64'(res_sum), 64'h5C00);
    chk("tvi_g4", 64'(tree_valid_in), 64'h1);
    chk("flat_g4", 64'(lane_diff(tree_in_flat, 16'h3C00)), 64'h0);

    // Drain the remaining tags 0,1,0 in order.
    req_valid = 2'b00;
    tree_sum  = 16'h1234;
    tick();
    chk("res2_valid", 64'(res_valid), 64'h1);
    chk("res2_sum", 64'(res_sum), 64'h1234);
    chk("tvi_none", 64'(tree_valid_in), 64'h0);
    tree_sum = 16'h4321;
    tick();
    chk("res3_valid", 64'(res_valid), 64'h2);
    chk("res3_sum", 64'(res_sum), 64'h4321);
    tree_sum = 16'hABCD;
    tick();
    chk("res4_valid", 64'(res_valid), 64'h1);
    chk("res4_sum", 64'(res_sum), 64'hABCD);
    tree_valid_out = 1'b0;
    tick();
    chk("res_quiet", 64'(res_valid), 64'h0);
    chk("busy_drained", 64'(busy), 64'h0);
    chk("orphan_clean", 64'(err_orphan), 64'h0);
`ifdef SCHED_PERF_CNT_EN
    chk("grant_cnt0", 64'(grant_cnt[31:0]), 64'd3);
    chk("grant_cnt1", 64'(grant_cnt[63:32]), 64'd2);
    chk("stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    // Orphan result: sticky error, no result pulse.
    tree_valid_out = 1'b1;
    tree_sum       = 16'h7777;
    tick();
    chk("orphan_set", 64'(err_orphan), 64'h1);
    chk("orphan_no_res", 64'(res_valid), 64'h0);
    tree_valid_out = 1'b0;
    tick();
    tick();
    chk("orphan_sticky", 64'(err_orphan), 64'h1);
    chk("orphan_quiet", 64'(res_valid), 64'h0);

    // Reset with reductions in flight and the pointer away from 0.
    req_valid = 2'b11;
    tick();
    tick();
    chk("ready_pre_rst", 64'(req_ready), 64'h2);
    chk("busy_pre_rst", 64'(busy), 64'h1);
    rst       = 1'b1;
    req_valid = 2'b00;
    tick();
    chk("mid_rst_tvi", 64'(tree_valid_in), 64'h0);
    chk("mid_rst_res", 64'(res_valid), 64'h0);
    chk("mid_rst_orphan", 64'(err_orphan), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_flat", 64'(lane_diff(tree_in_flat, 16'h0000)), 64'h0);
`ifdef SCHED_PERF_CNT_EN
    chk("mid_rst_gcnt", 64'(grant_cnt), 64'h0);
    chk("mid_rst_scnt", 64'(stall_cnt), 64'h0);
`endif
    rst       = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rr_restart", 64'(req_ready), 64'h1);
    // Tags were discarded, so a returning result is an orphan.
    req_valid      = 2'b00;
    tree_valid_out = 1'b1;
    tick();
    chk("post_rst_empty", 64'(err_orphan), 64'h1);
    chk("post_rst_no_res", 64'(res_valid), 64'h0);
    tree_valid_out = 1'b0;
    tick();
    chk("post_rst_quiet", 64'(res_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one fp16_adder_tree_128.
REQ-002 Parameter N, default 128: FP16 lanes per reduction.
REQ-003 Parameter DW, default 16: data width per lane.
REQ-004 Parameter MAX_INFLIGHT, default 128: tag FIFO depth, i.e. the maximum number of issued reductions not yet returned.
REQ-005 Ports are as follows; the design uses one clock, and reset is synchronous and active-high:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  bit i: requester i offers a vector.
- req_data  in  NREQ*N*DW  slice i is requester i's N lanes, lane j at bits [(i*N+j+1)*DW-1 -: DW].
- req_ready  out  NREQ  bit i: requester i granted this cycle.
- tree_valid_in  out  1  drives the tree's valid_in.
- tree_in_flat  out  N*DW  drives the tree's in_flat.
- tree_sum  in  DW  the tree's sum.
- tree_valid_out  in  1  the tree's valid_out.
- res_valid  out  NREQ  one-cycle pulse to the owning requester.
- res_sum  out  DW  result, valid only when any res_valid bit is set.
- busy  out  1  high while inflight count is nonzero or tree_valid_in is high.
- err_orphan  out  1  sticky flag: tree_valid_out arrived while the tag FIFO was empty.

Function
REQ-006 Transfer occurs when req_valid[i] and req_ready[i] are both high; at most one req_ready bit is high per cycle.
REQ-007 req_ready is combinational from req_valid, the round-robin pointer and the FIFO count: the first valid requester at or after the pointer, modulo NREQ, is granted; no grant is made while the FIFO count equals MAX_INFLIGHT.
REQ-008 The pointer becomes granted index + 1 (mod NREQ) after a grant and is unchanged otherwise.
REQ-009 On a transfer, tree_valid_in=1 and tree_in_flat=the granted slice on the next cycle; otherwise tree_valid_in=0 and tree_in_flat holds its last value.
REQ-010 Each transfer pushes the granted index, $clog2(NREQ) bits wide and minimum 1, into the tag FIFO at the same edge as REQ-009.
REQ-011 On tree_valid_out with the FIFO non-empty: pop the head tag; on the next cycle res_valid[tag]=1 and res_sum=tree_sum.
REQ-012 On tree_valid_out with the FIFO empty: no pop, no res_valid, err_orphan set to 1 until reset.
REQ-013 Push and pop in the same cycle leave the count unchanged, and the data path remains FIFO-ordered.
REQ-014 A full FIFO blocks grants even if a pop occurs in the same cycle; the pop only frees a slot from the next cycle.
REQ-015 Pointers wrap modulo MAX_INFLIGHT, and the count never exceeds MAX_INFLIGHT.
REQ-016 Latency from transfer edge to res_valid is 1 + tree latency + 1 cycles; with ADD_LAT=11 and depth 7 this is 79 cycles.
REQ-017 Sustained throughput is one reduction per cycle when MAX_INFLIGHT ≥ tree latency + 2.
REQ-018 Results are not back-pressured: a requester SHALL accept res_valid whenever it is pulsed.

Reset
REQ-019 On rst, outputs SHALL be: tree_valid_in=0, tree_in_flat=0, res_valid=0, res_sum=0, err_orphan=0, busy=0.
REQ-020 On rst, internal state SHALL be: FIFO count, read pointer and write pointer=0; round-robin pointer=0.
REQ-021 While rst is high, req_ready=0.
REQ-022 Reset mid-operation discards all in-flight tags; the integrator resets the tree with the same rst, so no stale valid_out returns.

Configuration
REQ-023 Macro SCHED_PERF_CNT_EN adds 32-bit output ports grant_cnt (NREQ*32) and stall_cnt (32), cleared on rst.
REQ-024 grant_cnt slice i SHALL count transfers from requester i, and stall_cnt SHALL count cycles in which some req_valid was high but no grant was made; both counters saturate at all-ones.
REQ-025 Without SCHED_PERF_CNT_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Shared package sched_pkg SHALL hold FP16 DW, default N, ADD_LAT=11, TREE_DEPTH=7, TREE_LAT=ADD_LAT*TREE_DEPTH, and the tag-width function.
REQ-027 Sub-module sched_tag_fifo, a synchronous FIFO with count output, depth MAX_INFLIGHT and width tag width, SHALL hold the tag FIFO; the arbiter logic is inline.

Verification
REQ-028 With NREQ=2, req_valid=2'b11 held for 4 cycles and a real tree attached: grants go 0,1,0,1, and res_valid pulses 0,1,0,1 at cycles 79..82 after the first transfer.
REQ-029 With requester 0 lanes all 0x3C00 (1.0) and requester 1 lanes all 0x4000 (2.0): res_sum is 0x5800 (128.0) for tag 0 and 0x5C00 (256.0) for tag 1.
REQ-030 With MAX_INFLIGHT=4 and req_valid=2'b01 held: exactly 4 grants, then req_ready=0 until the first pop; the 5th grant comes the cycle after that pop, and stall_cnt increments during the block when the macro is defined.
REQ-031 Inject tree_valid_out=1 with an empty FIFO: err_orphan=1, res_valid stays 0, and err_orphan remains 1 until rst.
REQ-032 Assert rst with 10 reductions in flight: the cycle after reset, busy=0, the FIFO count is 0, no res_valid pulses occur, and the round-robin pointer restarts at requester 0.
